xorshift_prng_mc: RTL and testbench

Multi-channel, parametrised xorshift PRNG engine. NUM_CH independent generators, each with its own seed and [low, high) range, served through a burst-request front end and a buffered valid/ready output stream. Generalises the single-channel 32-bit PRNG to 32/64-bit width, multiple channels and backpressure-tolerant output. Sits behind the AXI-Lite register slave of the PRNG IP.

---
 rtl/xorshift_prng_mc.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_xorshift_prng_mc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_prng_mc.sv
// xorshift_prng_mc: NUM_CH independent xorshift generators (32/64-bit) behind
// a burst-request front end and a credit-checked output FIFO.
// Optional feature macro: XORSHIFT_RANGE_MAP_EN builds the per-channel
// [low, high) registers plus a multiply map stage; without it out_range is 0
// and the FIFO is written one cycle earlier.
`timescale 1ns/1ps

// One generator channel: state register, step function, optional range regs.
module xorshift_lane #(
  parameter int               WIDTH     = 32,
  parameter int               CH        = 0,
  parameter logic [WIDTH-1:0] BASE_SEED = WIDTH'(32'h24635342)
`ifdef XORSHIFT_RANGE_MAP_EN
  ,
  parameter logic [WIDTH-1:0] RST_LOW   = '0,
  parameter logic [WIDTH-1:0] RST_HIGH  = WIDTH'(100)
`endif
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             soft_rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             step,
  output logic [WIDTH-1:0] nxt
`ifdef XORSHIFT_RANGE_MAP_EN
  ,
  input  logic             rng_we,
  input  logic [WIDTH-1:0] lo_data,
  input  logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] low,
  output logic [WIDTH-1:0] high
`endif
);
  // Channel default seed is the base seed rotated left by the channel index,
  // so it stays nonzero and differs per channel.
  localparam logic [WIDTH-1:0] RST_SEED = (BASE_SEED << CH) | (BASE_SEED >> (WIDTH - CH));

  logic [WIDTH-1:0] state;

  function automatic logic [WIDTH-1:0] xs_step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x ^ (x << 13);
    if (WIDTH == 64) begin
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
    end else begin
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
    end
    return y;
  endfunction

  assign nxt = xs_step(state);

  // Generator state: reset/soft reset to default, seed write (0 -> default), or step.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)      state <= RST_SEED;
    else if (soft_rst) state <= RST_SEED;
    else if (seed_we)  state <= (seed_data == '0) ? RST_SEED : seed_data;
    else if (step)     state <= nxt;
  end

`ifdef XORSHIFT_RANGE_MAP_EN
  // Range registers; an empty or inverted range collapses to span 1 at low.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      low  <= RST_LOW;
      high <= RST_HIGH;
    end else if (soft_rst) begin
      low  <= RST_LOW;
      high <= RST_HIGH;
    end else if (rng_we) begin
      low  <= lo_data;
      high <= (hi_data <= lo_data) ? lo_data + WIDTH'(1) : hi_data;
    end
  end
`endif
endmodule

module xorshift_prng_mc #(
  parameter int          WIDTH        = 32,
  parameter int          NUM_CH       = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [63:0] DEFAULT_SEED = 64'h24635342,
  parameter logic [63:0] DEFAULT_LOW  = 64'd0,
  parameter logic [63:0] DEFAULT_HIGH = 64'd100
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             prng_reset,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [2:0]       cfg_ch,
  input  logic [WIDTH-1:0] cfg_data0,
  input  logic [WIDTH-1:0] cfg_data1,
  output logic             cfg_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_ch,
  input  logic [7:0]       req_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_ch,
  output logic [WIDTH-1:0] out_raw,
  output logic [WIDTH-1:0] out_range,
  output logic             out_last
);
  localparam int         AW  = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NCH = 4'(NUM_CH);
`ifdef XORSHIFT_RANGE_MAP_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef struct packed {
    logic [2:0]       ch;
    logic [WIDTH-1:0] raw;
`ifdef XORSHIFT_RANGE_MAP_EN
    logic [WIDTH-1:0] rng;
`endif
    logic             last;
  } entry_t;

  typedef enum logic {IDLE, GEN} state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   ch_q, ch_d;
  logic [7:0]                   rem_q, rem_d;
  logic                         cfg_fire, req_fire, launch, can_step;
  logic [NUM_CH-1:0]            seed_we_v, step_v;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_nxt;
  logic [WIDTH-1:0]             raw_sel;
  logic [STAGES:1]              vld_pipe;
  logic [2:0]                   s1_ch;
  logic [WIDTH-1:0]             s1_raw;
  logic                         s1_last;
  entry_t                       fifo_din, head;
  logic                         fifo_wr, fifo_rd;
  entry_t                       mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [AW:0]                  fifo_cnt;

  // Config and requests share one handshake; out-of-range channels are
  // accepted but decode to nothing.
  assign cfg_ready = (state_q == IDLE) && !prng_reset;
  assign req_ready = cfg_ready;
  assign cfg_fire  = cfg_we && cfg_ready && ({1'b0, cfg_ch} < NCH);
  assign req_fire  = req_valid && req_ready && ({1'b0, req_ch} < NCH) && (req_count != 8'd0);

`ifdef XORSHIFT_RANGE_MAP_EN
  logic [NUM_CH-1:0]            rng_we_v;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_low, lane_high;
`else
  logic [WIDTH-1:0]             unused_cfg;
  localparam logic [63:0]       unused_rng_dflt = DEFAULT_LOW ^ DEFAULT_HIGH;
  assign unused_cfg = cfg_data1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign seed_we_v[g] = cfg_fire && !cfg_sel && (cfg_ch == 3'(g));
    assign step_v[g]    = launch && (ch_q == 3'(g));
`ifdef XORSHIFT_RANGE_MAP_EN
    assign rng_we_v[g]  = cfg_fire && cfg_sel && (cfg_ch == 3'(g));
`endif
    xorshift_lane #(
      .WIDTH     (WIDTH),
      .CH        (g),
      .BASE_SEED (DEFAULT_SEED[WIDTH-1:0])
`ifdef XORSHIFT_RANGE_MAP_EN
      ,
      .RST_LOW   (DEFAULT_LOW[WIDTH-1:0]),
      .RST_HIGH  (DEFAULT_HIGH[WIDTH-1:0])
`endif
    ) u_lane (
      .clk       (clk),
      .aresetn   (aresetn),
      .soft_rst  (prng_reset),
      .seed_we   (seed_we_v[g]),
      .seed_data (cfg_data0),
      .step      (step_v[g]),
      .nxt       (lane_nxt[g])
`ifdef XORSHIFT_RANGE_MAP_EN
      ,
      .rng_we    (rng_we_v[g]),
      .lo_data   (cfg_data0),
      .hi_data   (cfg_data1),
      .low       (lane_low[g]),
      .high      (lane_high[g])
`endif
    );
  end

  // Credit check: never launch more than the FIFO can hold, counting in-flight stages.
  assign can_step = (int'(fifo_cnt) + $countones(vld_pipe)) < FIFO_DEPTH;

  // Next-value mux for the active channel.
  always_comb begin
    raw_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_q == 3'(i)) raw_sel = lane_nxt[i];
  end

  // FSM next state: IDLE latches a burst, GEN steps once per cycle with credit.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: if (req_fire) begin
        state_d = GEN;
        ch_d    = req_ch;
        rem_d   = req_count;
      end
      GEN: if (can_step) begin
        launch = 1'b1;
        rem_d  = rem_q - 8'd1;
        if (rem_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; soft reset aborts any burst.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rem_q   <= '0;
    end else if (prng_reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
    end
  end

  // Launch stage: captures the freshly stepped value plus burst tag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe <= '0;
      s1_ch    <= '0;
      s1_raw   <= '0;
      s1_last  <= 1'b0;
    end else if (prng_reset) begin
      vld_pipe <= '0;
      s1_ch    <= '0;
      s1_raw   <= '0;
      s1_last  <= 1'b0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | STAGES'(launch);
      if (launch) begin
        s1_ch   <= ch_q;
        s1_raw  <= raw_sel;
        s1_last <= (rem_q == 8'd1);
      end
    end
  end

`ifdef XORSHIFT_RANGE_MAP_EN
  logic [WIDTH-1:0]   lo_sel, hi_sel, span;
  logic [2*WIDTH-1:0] prod;
  entry_t             s2_q;

  // Range map: low + upper half of raw*span, always inside [low, high).
  always_comb begin
    lo_sel = '0;
    hi_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (s1_ch == 3'(i)) begin
        lo_sel = lane_low[i];
        hi_sel = lane_high[i];
      end
    span = hi_sel - lo_sel;
    prod = {{WIDTH{1'b0}}, s1_raw} * {{WIDTH{1'b0}}, span};
  end

  // Map stage register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)             s2_q <= '0;
    else if (prng_reset)      s2_q <= '0;
    else if (vld_pipe[1]) begin
      s2_q.ch   <= s1_ch;
      s2_q.raw  <= s1_raw;
      s2_q.rng  <= lo_sel + prod[2*WIDTH-1:WIDTH];
      s2_q.last <= s1_last;
    end
  end

  assign fifo_din = s2_q;
`else
  // Without mapping the launch stage feeds the FIFO directly.
  always_comb begin
    fifo_din      = '0;
    fifo_din.ch   = s1_ch;
    fifo_din.raw  = s1_raw;
    fifo_din.last = s1_last;
  end
`endif

  assign fifo_wr = vld_pipe[STAGES];
  assign fifo_rd = out_valid && out_ready;

  // FIFO storage; contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= fifo_din;
  end

  // FIFO pointers and occupancy; push and pop in the same cycle cancel.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (prng_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_cnt != '0);
  assign out_ch    = out_valid ? head.ch   : '0;
  assign out_raw   = out_valid ? head.raw  : '0;
  assign out_last  = out_valid ? head.last : 1'b0;
`ifdef XORSHIFT_RANGE_MAP_EN
  assign out_range = out_valid ? head.rng  : '0;
`else
  assign out_range = '0;
`endif
endmodule

// File: tb/tb_xorshift_prng_mc.sv
// Scoreboard bench for xorshift_prng_mc: a software model pushes expected
// entries on each accepted request; a monitor pops and compares on each pop.
`timescale 1ns/1ps

module tb_xorshift_prng_mc;
  localparam int W     = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
`ifdef XORSHIFT_RANGE_MAP_EN
  localparam bit MAP_EN = 1'b1;
  localparam int LAT    = 3;
`else
  localparam bit MAP_EN = 1'b0;
  localparam int LAT    = 2;
`endif

  logic         clk, aresetn, prng_reset;
  logic         cfg_we, cfg_sel, cfg_ready;
  logic [2:0]   cfg_ch;
  logic [W-1:0] cfg_data0, cfg_data1;
  logic         req_valid, req_ready;
  logic [2:0]   req_ch;
  logic [7:0]   req_count;
  logic         out_valid, out_ready, out_last;
  logic [2:0]   out_ch;
  logic [W-1:0] out_raw, out_range;

  typedef struct {
    logic [2:0]   ch;
    logic [W-1:0] raw;
    logic [W-1:0] rng;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_s  [NCH];
  logic [W-1:0] m_lo [NCH];
  logic [W-1:0] m_hi [NCH];
  int           n_chk = 0;
  int           n_err = 0;
  int           n_pop = 0;

  xorshift_prng_mc #(.WIDTH(W), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .aresetn(aresetn), .prng_reset(prng_reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
    .cfg_data0(cfg_data0), .cfg_data1(cfg_data1), .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_count(req_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_raw(out_raw), .out_range(out_range), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] xs32(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [W-1:0] dseed(input int ch);
    logic [W-1:0] b;
    b = 32'h24635342;
    return (ch == 0) ? b : ((b << ch) | (b >> (W - ch)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_s[i]  = dseed(i);
      m_lo[i] = 32'd0;
      m_hi[i] = 32'd100;
    end
  endtask

  task automatic model_cfg(input bit sel, input int ch, input logic [W-1:0] d0, input logic [W-1:0] d1);
    if (ch < NCH) begin
      if (!sel) m_s[ch] = (d0 == 0) ? dseed(ch) : d0;
      else if (MAP_EN) begin
        m_lo[ch] = d0;
        m_hi[ch] = (d1 <= d0) ? d0 + 32'd1 : d1;
      end
    end
  endtask

  task automatic model_req(input int ch, input int cnt);
    exp_t        e;
    logic [63:0] p;
    if (ch < NCH) begin
      for (int i = 0; i < cnt; i++) begin
        m_s[ch] = xs32(m_s[ch]);
        p       = 64'(m_s[ch]) * 64'(m_hi[ch] - m_lo[ch]);
        e.ch    = 3'(ch);
        e.raw   = m_s[ch];
        e.rng   = MAP_EN ? m_lo[ch] + p[63:32] : 32'd0;
        e.last  = (i == cnt - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic cfg_write(input bit sel, input int ch, input logic [W-1:0] d0, input logic [W-1:0] d1);
    int t = 0;
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = 3'(ch); cfg_data0 = d0; cfg_data1 = d1;
    @(negedge clk);
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    chk("cfg_accept", cfg_ready, 1);
    if (cfg_ready) model_cfg(sel, ch, d0, d1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_req(input int ch, input int cnt);
    int t = 0;
    req_valid = 1'b1; req_ch = 3'(ch); req_count = 8'(cnt);
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    chk("req_accept", req_ready, 1);
    if (req_ready) model_req(ch, cnt);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 1000) begin @(posedge clk); t++; end
    chk("drain_left", exp_q.size(), 0);
    #1;
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (aresetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected_valid", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_raw", out_raw, e.raw);
        chk("out_range", out_range, e.rng);
        chk("out_last", out_last, e.last);
        n_pop++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit, %0d checks %0d errors so far", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    int base, t;
    aresetn = 1'b0; prng_reset = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_data0 = '0; cfg_data1 = '0;
    req_valid = 1'b0; req_ch = '0; req_count = '0; out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_raw", out_raw, 0);
    chk("rst_range", out_range, 0);
    chk("rst_last", out_last, 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Seed 1 on ch0, range [0,100), single value; latency and known value
    cfg_write(1'b0, 0, 32'd1, 32'd0);
    cfg_write(1'b1, 0, 32'd0, 32'd100);
    do_req(0, 1);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      chk("lat_valid", out_valid, (k >= LAT) ? 1 : 0);
    end
    chk("t1_raw", out_raw, 32'h00042021);
    chk("t1_range", out_range, 0);
    chk("t1_last", out_last, 1);
    wait_drain();

    // ch1 range [50,150), 20 values under random backpressure
    cfg_write(1'b1, 1, 32'd50, 32'd150);
    do_req(1, 20);
    repeat (40) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    wait_drain();

    // Inverted range on ch2 collapses to low; all-ones low wraps high to 0
    cfg_write(1'b1, 2, 32'd100, 32'd50);
    do_req(2, 4);
    wait_drain();
    cfg_write(1'b1, 2, 32'hFFFF_FFFF, 32'd0);
    do_req(2, 2);
    wait_drain();

    // FIFO fills and holds with out_ready low, then streams in order
    out_ready = 1'b0;
    do_req(0, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_valid", out_valid, 1);
    chk("full_head_raw", out_raw, exp_q[0].raw);
    chk("full_busy", req_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Seed 0 on ch3 restores its default sequence; ch0 bursts do not disturb it
    do_req(3, 3);
    do_req(0, 5);
    cfg_write(1'b0, 3, 32'd0, 32'd0);
    do_req(3, 3);
    do_req(0, 2);
    do_req(3, 2);
    wait_drain();

    // Out-of-range channel and zero count produce nothing
    cfg_write(1'b0, 6, 32'd123, 32'd0);
    do_req(5, 3);
    do_req(0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ignored_valid", out_valid, 0);
    @(posedge clk); #1;
    do_req(0, 1);
    wait_drain();

    // Soft reset mid-burst aborts output; state returns to defaults
    do_req(0, 50);
    base = n_pop;
    t = 0;
    while (n_pop - base < 5 && t < 500) begin @(posedge clk); t++; end
    chk("abort_pops", (n_pop - base >= 5) ? 1 : 0, 1);
    #1;
    out_ready  = 1'b0;
    prng_reset = 1'b1;
    @(negedge clk);
    chk("srst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    prng_reset = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_raw", out_raw, 0);
    repeat (5) @(negedge clk);
    chk("abort_quiet", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_req(0, 1);
    wait_drain();
    do_req(1, 3);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
